// File: rtl/conv_sys_array_param.sv
// conv_sys_array_param: streaming KxK fixed-point convolution over a row-major pixel stream.
// Define RELU_EN to clamp negative saturated results to zero in-line.
module conv_sys_array_param #(
  parameter int DW    = 16,
  parameter int K     = 3,
  parameter int IMG_W = 7,
  parameter int IMG_H = 7,
  parameter int FRAC  = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load_w,
  input  logic [DW-1:0] w_in,
  input  logic          w_valid,
  input  logic          start,
  input  logic [DW-1:0] px_in,
  input  logic          px_valid,
  output logic          px_ready,
  output logic [DW-1:0] result,
  output logic          res_valid,
  output logic          res_last,
  output logic          srt_pool,
  output logic          end_sig,
  output logic          busy
);
  localparam int NK = K * K;
  localparam int NT = (K - 1) * IMG_W + K;
  localparam int AW = 2 * DW + $clog2(NK);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam int WW = $clog2(NK);
  localparam logic [CW-1:0] COL_MAX = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_MAX = RW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_K = CW'(K - 1);
  localparam logic [RW-1:0] ROW_K = RW'(K - 1);
  localparam logic [WW-1:0] WI_MAX = WW'(NK - 1);
  localparam logic signed [AW-1:0] MAXV = {{(AW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [AW-1:0] MINV = {{(AW-DW+1){1'b1}}, {(DW-1){1'b0}}};

  typedef enum logic [2:0] {IDLE, LOAD_W, RUN, DRAIN, DONE} state_t;
  state_t r_state, w_next;

  logic [WW-1:0] r_widx;
  logic [CW-1:0] r_col;
  logic [RW-1:0] r_row;
  logic signed [DW-1:0] r_w [NK];
  logic signed [DW-1:0] r_sr [1:NT-1];
  logic signed [DW-1:0] w_tap [NT];
  logic signed [DW-1:0] w_win [NK];
  logic signed [2*DW-1:0] r_prod [NK];
  logic signed [AW-1:0] r_acc, w_sum, w_sh;
  logic [DW-1:0] w_sat, w_res;
  logic r_v1, r_l1, r_v2, r_l2;
  logic w_acc, w_last_px;

  assign busy      = r_state != IDLE;
  assign px_ready  = r_state == RUN;
  assign w_acc     = px_valid && px_ready;
  assign w_last_px = w_acc && r_row == ROW_MAX && r_col == COL_MAX;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else r_state <= w_next;

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = load_w ? LOAD_W : start ? RUN : IDLE;
      LOAD_W:  w_next = (w_valid && r_widx == WI_MAX) ? IDLE : LOAD_W;
      RUN:     w_next = w_last_px ? DRAIN : RUN;
      DRAIN:   w_next = res_last ? DONE : DRAIN;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_widx <= '0;
      r_col  <= '0;
      r_row  <= '0;
      for (int t = 0; t < NK; t++) r_w[t] <= '0;
      for (int t = 1; t < NT; t++) r_sr[t] <= '0;
    end else begin
      if (r_state == IDLE && load_w) r_widx <= '0;
      else if (r_state == LOAD_W && w_valid) begin
        r_w[r_widx] <= $signed(w_in);
        r_widx <= r_widx == WI_MAX ? '0 : r_widx + WW'(1);
      end
      if (r_state == IDLE && start && !load_w) begin
        r_col <= '0;
        r_row <= '0;
      end else if (w_acc) begin
        r_col <= r_col == COL_MAX ? '0 : r_col + CW'(1);
        r_row <= r_col == COL_MAX ? r_row + RW'(1) : r_row;
        r_sr[1] <= w_tap[0];
        for (int t = 2; t < NT; t++) r_sr[t] <= r_sr[t-1];
      end
    end

  // The shift chain holds K-1 full rows plus K-1 pixels; tap 0 is the live input.
  always_comb begin
    w_tap[0] = $signed(px_in);
    for (int t = 1; t < NT; t++) w_tap[t] = r_sr[t];
    for (int i = 0; i < K; i++)
      for (int j = 0; j < K; j++)
        w_win[i*K+j] = w_tap[(K-1-i)*IMG_W + (K-1-j)];
  end

  always_comb begin
    w_sum = '0;
    for (int t = 0; t < NK; t++) w_sum = w_sum + AW'(r_prod[t]);
  end

  always_comb begin
    w_sh  = r_acc >>> FRAC;
    w_sat = w_sh > MAXV ? MAXV[DW-1:0] : w_sh < MINV ? MINV[DW-1:0] : w_sh[DW-1:0];
`ifdef RELU_EN
    w_res = w_sat[DW-1] ? '0 : w_sat;
`else
    w_res = w_sat;
`endif
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int t = 0; t < NK; t++) r_prod[t] <= '0;
      r_v1      <= 1'b0;
      r_l1      <= 1'b0;
      r_v2      <= 1'b0;
      r_l2      <= 1'b0;
      r_acc     <= '0;
      result    <= '0;
      res_valid <= 1'b0;
      res_last  <= 1'b0;
      srt_pool  <= 1'b0;
      end_sig   <= 1'b0;
    end else begin
      for (int t = 0; t < NK; t++) r_prod[t] <= (2*DW)'(w_win[t]) * (2*DW)'(r_w[t]);
      r_v1      <= w_acc && r_row >= ROW_K && r_col >= COL_K;
      r_l1      <= w_last_px;
      r_acc     <= w_sum;
      r_v2      <= r_v1;
      r_l2      <= r_l1;
      result    <= r_v2 ? w_res : result;
      res_valid <= r_v2;
      res_last  <= r_l2;
      srt_pool  <= (res_valid && res_last) ? 1'b0 : r_v2 ? 1'b1 : srt_pool;
      end_sig   <= (r_state == DRAIN && res_last) ? 1'b1 :
                   (r_state == IDLE && (load_w || start)) ? 1'b0 : end_sig;
    end
endmodule

// File: tb/tb_conv_sys_array_param.sv
// tb_conv_sys_array_param: scoreboard bench for the 3x3 / 7x7 default build of conv_sys_array_param.
module tb_conv_sys_array_param;
  logic clk = 1'b0, rst_n = 1'b0, load_w = 1'b0, w_valid = 1'b0, start = 1'b0, px_valid = 1'b0;
  logic [15:0] w_in = '0, px_in = '0;
  logic px_ready, res_valid, res_last, srt_pool, end_sig, busy;
  logic [15:0] result;
  int tests = 0, fails = 0, cyc = 0;
  int acc_edge16 = -1, first_edge = -1, nres = 0, nsrt = 0;
  logic [16:0] q [$];
  logic [15:0] w_id [9], w_256 [9], w_max [9], w_min [9];

  conv_sys_array_param dut (
    .clk(clk), .rst_n(rst_n), .load_w(load_w), .w_in(w_in), .w_valid(w_valid),
    .start(start), .px_in(px_in), .px_valid(px_valid), .px_ready(px_ready),
    .result(result), .res_valid(res_valid), .res_last(res_last),
    .srt_pool(srt_pool), .end_sig(end_sig), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_result"}, int'(result), 0);
    chk({tag, "_res_valid"}, int'(res_valid), 0);
    chk({tag, "_res_last"}, int'(res_last), 0);
    chk({tag, "_srt_pool"}, int'(srt_pool), 0);
    chk({tag, "_end_sig"}, int'(end_sig), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_px_ready"}, int'(px_ready), 0);
  endtask

  always @(negedge clk) begin : monitor
    logic [16:0] e;
    if (rst_n && res_valid) begin
      nres++;
      if (srt_pool) nsrt++;
      if (first_edge < 0) first_edge = cyc;
      if (q.size() == 0) chk("unexpected_result", 1, 0);
      else begin
        e = q.pop_front();
        chk("result", int'($signed(result)), int'($signed(e[15:0])));
        chk("res_last", int'(res_last), int'(e[16]));
      end
    end
  end

  task automatic load(input logic [15:0] w [9], input bit gaps);
    @(negedge clk) load_w = 1'b1;
    @(negedge clk) load_w = 1'b0;
    for (int i = 0; i < 9; i++) begin
      if (gaps) begin
        w_valid = 1'b0;
        start = (i == 4);
        @(negedge clk) start = 1'b0;
      end
      if (i == 8) chk("busy_in_load", int'(busy), 1);
      w_valid = 1'b1;
      w_in = w[i];
      @(negedge clk);
    end
    w_valid = 1'b0;
    chk("idle_after_load", int'(busy), 0);
    @(negedge clk) chk("still_idle_after_load", int'(busy), 0);
  endtask

  task automatic run_frame(input bit ramp, input logic [15:0] pv, input logic [15:0] ev,
                           input bit gaps, input int abort_at);
    int idx = 0, t = 0, r, c, n;
    bit kicked = 1'b0;
    n = abort_at > 0 ? abort_at : 49;
    first_edge = -1;
    nres = 0;
    nsrt = 0;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    chk("end_sig_cleared", int'(end_sig), 0);
    while (idx < n && t < 2000) begin
      px_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      px_in = ramp ? 16'(idx) : pv;
      start = (idx == 25 && !kicked);
      if (start) kicked = 1'b1;
      if (px_valid && px_ready) begin
        r = idx / 7;
        c = idx % 7;
        if (r >= 2 && c >= 2) q.push_back({idx == 48, ramp ? 16'((r - 1) * 7 + c - 1) : ev});
        if (idx == 16) acc_edge16 = cyc + 1;
        idx++;
      end
      @(negedge clk);
      t++;
    end
    px_valid = 1'b0;
    start = 1'b0;
    if (idx != n) chk("feed_timeout", idx, n);
    if (abort_at > 0) begin
      rst_n = 1'b0;
      #1;
      chk_idle_outputs("abort");
      q.delete();
      @(negedge clk) rst_n = 1'b1;
      return;
    end
    chk("px_ready_after_last", int'(px_ready), 0);
    t = 0;
    while (!end_sig && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("end_sig_set", int'(end_sig), 1);
    chk("result_count", nres, 25);
    chk("srt_pool_count", nsrt, 25);
    chk("latency", first_edge - acc_edge16, 2);
    chk("queue_empty", q.size(), 0);
    @(negedge clk);
    chk("idle_after_done", int'(busy), 0);
    chk("end_sig_held", int'(end_sig), 1);
    chk("srt_pool_low", int'(srt_pool), 0);
  endtask

  initial begin
    for (int i = 0; i < 9; i++) begin
      w_id[i]  = (i == 4) ? 16'd256 : 16'd0;
      w_256[i] = 16'd256;
      w_max[i] = 16'h7FFF;
      w_min[i] = 16'h8000;
    end
    repeat (3) @(negedge clk);
    chk_idle_outputs("reset");
    rst_n = 1'b1;
    load(w_id, 1'b1);
    run_frame(1'b1, 16'd0, 16'd0, 1'b0, 0);
    run_frame(1'b1, 16'd0, 16'd0, 1'b1, 0);
    load(w_256, 1'b0);
    run_frame(1'b0, 16'd256, 16'd2304, 1'b0, 0);
    load(w_max, 1'b0);
    run_frame(1'b0, 16'h7FFF, 16'h7FFF, 1'b0, 0);
    load(w_min, 1'b0);
`ifdef RELU_EN
    run_frame(1'b0, 16'h7FFF, 16'h0000, 1'b0, 0);
`else
    run_frame(1'b0, 16'h7FFF, 16'h8000, 1'b0, 0);
`endif
    load(w_256, 1'b0);
    run_frame(1'b0, 16'd256, 16'd2304, 1'b0, 20);
    run_frame(1'b0, 16'd256, 16'd0, 1'b0, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, %0d failures so far", fails);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/conv_sys_array_param.md
Name: conv_sys_array_param

Overview:
Parametrised streaming 2-D convolution engine. It is the KxK generalisation of the fixed 3x3 feature-map array. It holds a KxK weight kernel and accepts a row-major pixel stream with a valid/ready handshake. Internally it builds sliding windows from K-1 line buffers and emits one fixed-point, saturated result per valid window to the downstream pooling stage.

Parameters:
DW, 16, signed width of pixels, weights and results
K, 3, kernel edge (2..7)
IMG_W, 7, feature-map width in pixels (>= K)
IMG_H, 7, feature-map height in pixels (>= K)
FRAC, 8, fractional bits; accumulator is arithmetically shifted right by FRAC before saturation

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
load_w  input  1  one-cycle pulse; enter weight-load mode
w_in  input  DW  weight word, row-major, kernel (0,0) first
w_valid  input  1  w_in valid
start  input  1  one-cycle pulse; begin a frame
px_in  input  DW  pixel, row-major
px_valid  input  1  px_in valid
px_ready  output  1  engine accepts pixel this cycle
result  output  DW  convolution result
res_valid  output  1  result valid
res_last  output  1  last result of frame, qualifies res_valid
srt_pool  output  1  high from first res_valid cycle through res_last cycle
end_sig  output  1  frame complete; level until next start or load_w
busy  output  1  state != IDLE

Behaviour:
- Reset: rst_n is asynchronous active-low on clk. All outputs reset to 0. State = IDLE. Weights, line buffers, counters and pipeline are all cleared to 0.
- States:
  - IDLE: load_w -> LOAD_W; start -> RUN. If both are high, load_w wins. Either one clears end_sig.
  - LOAD_W: each w_valid cycle writes w_in to the next weight slot. After the K*K-th word -> IDLE. start is ignored in this state.
  - RUN: px_ready=1. A pixel is accepted when px_valid && px_ready. Column/row counters advance on each accept, column wrapping at IMG_W-1. After IMG_W*IMG_H accepts -> DRAIN; px_ready drops to 0 in the cycle following the last accept.
  - DRAIN: wait for the pipeline to empty. When res_last is emitted -> DONE.
  - DONE: end_sig=1, then -> IDLE next cycle. end_sig stays high until the next start or load_w.
- load_w and start are ignored in RUN and DRAIN. px_valid outside RUN is ignored.
- Window: on a pixel accepted at (r,c) with r>=K-1 and c>=K-1, the window with bottom-right corner (r,c) is valid. Windows straddling the row wrap are never emitted. The frame yields exactly (IMG_H-K+1)*(IMG_W-K+1) results, in row-major order.
- Latency: the result for a window accepted at edge n has res_valid=1 in the cycle after edge n+2, i.e. 3 cycles after the accept.
  - Stage 1: register window and K*K products.
  - Stage 2: adder tree into the accumulator.
  - Stage 3: shift and saturate.
  - The pipeline advances every cycle regardless of px_valid gaps. Input stalls produce gaps in res_valid; results are never reordered or dropped.
- Arithmetic:
  - Products are 2*DW signed.
  - Accumulator width = 2*DW + ceil(log2(K*K)); no overflow is possible.
  - acc >>> FRAC (arithmetic), then saturate to [-2^(DW-1), 2^(DW-1)-1].
- There is no output backpressure; the consumer must accept every res_valid cycle.
- A reset mid-frame aborts immediately. No partial result appears after reset is released.
- Weights persist across frames until the next LOAD_W or reset.

Optional Feature:
RELU_EN defined: saturated negative results are replaced by 0 before the result register, giving ReLU in-line. Undefined: signed saturated results pass unchanged. Latency is identical in both cases.

Test Plan:
- Identity kernel (center=256, others 0, FRAC=8) on a 7x7 ramp 0..48 -> 25 results 8,9,10,11,12,15,...,40. res_last on the 25th result; end_sig then high.
- All weights 256, all pixels 256 -> every result 2304. First res_valid 3 cycles after pixel (2,2) is accepted. srt_pool high for exactly 25 consecutive res_valid cycles when px_valid is held high.
- Saturation: weights 0x7FFF, pixels 0x7FFF -> every result 32767. Weights 0x8000, pixels 0x7FFF -> -32768, or 0 with RELU_EN.
- Random px_valid gaps (50% duty) on the ramp frame -> same 25 values in the same order as the no-gap run; px_ready=0 after the 49th accept.
- Weight load: pulse load_w, then 9 w_valid words with idle gaps and start asserted mid-load -> start is ignored, all 9 weights are loaded, state returns to IDLE. start asserted during RUN -> no effect.
- Assert rst_n low after 20 accepted pixels -> all outputs 0 and state IDLE. Weights cleared, so a new start with no reload on the all-256 frame yields 25 results of 0.
